riscv_wb_arbiter: RTL
=====================

// Module: riscv_wb_arbiter
// PURPOSE
//   Writeback arbiter: drives the two write ports (A, B) of riscv_register_file from three producers.
//   Producers: EX (single-cycle ALU/MUL), LSU (load data) and MC (multicycle DIV/FPU).
//   EX owns port A. LSU and MC share port B; MC results are buffered in a small FIFO.
//   Outputs are registered; resolves same-register collisions in program order.
// PARAMETERS
//   ADDR_WIDTH  6   register address width; bit 5 selects FP bank when FPU=1
//   DATA_WIDTH  32  result width
//   FIFO_DEPTH  2   MC result buffer entries (power of 2, >=2)
//   STARVE_MAX  4   consecutive MC-pending cycles lost to LSU before MC is forced onto port B
// PORTS
//   clk           in   1           core clock
//   rst_n         in   1           async reset, active low
//   ex_valid_i    in   1           EX result valid (always accepted, no ready)
//   ex_addr_i     in   ADDR_WIDTH  EX destination register
//   ex_data_i     in   DATA_WIDTH  EX result
//   ex_tag_i      in   1           EX result tag
//   lsu_valid_i   in   1           LSU result valid
//   lsu_ready_o   out  1           LSU result accepted this cycle
//   lsu_addr_i / lsu_data_i / lsu_tag_i  in  ADDR_WIDTH / DATA_WIDTH / 1  LSU result
//   mc_valid_i    in   1           MC result valid
//   mc_ready_o    out  1           MC result accepted (FIFO not full)
//   mc_addr_i / mc_data_i / mc_tag_i     in  ADDR_WIDTH / DATA_WIDTH / 1  MC result
//   we_a_o, waddr_a_o, wdata_a_o, wtag_a_o   out  1/ADDR_WIDTH/DATA_WIDTH/1  regfile port A
//   we_b_o, waddr_b_o, wdata_b_o, wtag_b_o   out  1/ADDR_WIDTH/DATA_WIDTH/1  regfile port B
//   mc_fifo_empty_o out 1          MC buffer empty (used by controller for fence/debug drain)
// BEHAVIOUR
//   - Reset: all outputs 0 except mc_ready_o=1, mc_fifo_empty_o=1; FIFO flushed, starve counter 0.
//   - Reset mid-operation drops buffered MC results; no write is issued after rst_n falls.
//   - Latency: accept in cycle N -> we_*_o/addr/data/tag valid in cycle N+1, held exactly one cycle.
//   - Port A: we_a_o <= ex_valid_i && ex_addr_i!=0. Address 0 accepted and silently dropped.
//   - MC accept: mc_valid_i && mc_ready_o pushes the FIFO; mc_ready_o = !full.
//   - Full FIFO with a simultaneous pop accepts the push (ready = !full || pop).
//   - Port B candidate, priority order:
//       1. FIFO head, if starve_cnt==STARVE_MAX;
//       2. LSU, if lsu_valid_i;
//       3. FIFO head, if non-empty.
//   - lsu_ready_o = lsu_valid_i && !(FIFO forced). Candidate consumed in the selecting cycle.
//   - starve_cnt: increments when FIFO non-empty and LSU wins; clears on any pop; saturates at STARVE_MAX.
//   - Empty FIFO bypass: MC push with empty FIFO and no LSU -> written directly (same latency), no FIFO entry.
//   - Collision (EX and B candidate target the same nonzero addr, same cycle):
//       EX is younger and wins on port A.
//       B candidate is still consumed (ready/pop) but we_b_o=0.
//   - B candidate addr 0: consumed, we_b_o=0.
//   - Port A and port B never assert with equal waddr in the same cycle.
// CONFIGURATION
//   RISCV_WB_SCOREBOARD_EN defined:
//     adds iss_valid_i(1), iss_addr_i(ADDR_WIDTH) and busy_o(2**ADDR_WIDTH).
//     busy_o[r] is set the cycle after an LSU/MC instruction issues to r (r!=0).
//     busy_o[r] is cleared the cycle after the result for r is consumed (written or collision-dropped).
//     Set and clear of the same r in one cycle: set wins. Reset: busy_o=0.
//   Undefined: none of these ports exist; no scoreboard flops.
// STRUCTURE
//   riscv_wb_pkg: wb_req_t struct {addr, data, tag}; enum wb_src_e {SRC_NONE, SRC_LSU, SRC_MC}.
//   Sub-module riscv_wb_fifo: FIFO_DEPTH x wb_req_t, push/pop/full/empty, async active-low reset.
//   Top level contains the arbitration, starve counter, output registers and optional scoreboard.
// TESTING
//   - EX x5=0x1234 -> next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0x1234; we_a_o=0 the cycle after.
//   - LSU x7 and MC x9 same cycle, FIFO empty -> LSU on port B at N+1; MC written to x9 at N+2.
//   - LSU valid continuously, MC pending -> after 4 LSU wins, lsu_ready_o=0 one cycle and MC written.
//   - MC push with FIFO full and no pop -> mc_ready_o=0; push with simultaneous pop -> accepted.
//   - EX x3=0xA and LSU x3=0xB same cycle -> we_a_o=1 with data 0xA; we_b_o=0; lsu_ready_o=1.
//   - Scoreboard: issue x12 -> busy_o[12]=1; MC result x12 written -> busy_o[12]=0 next cycle.
//     rst_n low mid-run -> busy_o=0 and FIFO empty.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared types for the writeback arbiter: result request record and
// port-B source select. Widths here fix the record layout used by the
// arbiter and its MC result buffer.
package riscv_wb_pkg;

   localparam int WB_ADDR_W = 6;
   localparam int WB_DATA_W = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic                 tag;
   } wb_req_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_LSU  = 2'd1,
      SRC_MC   = 2'd2
   } wb_src_e;

endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// Bus bundle between the three result producers, the arbiter and the
// register file write ports. slave = arbiter view, master = driver view.
// Optional scoreboard signals exist only with RISCV_WB_SCOREBOARD_EN.
interface riscv_wb_arbiter_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic                  ex_valid_i;
   logic [ADDR_WIDTH-1:0] ex_addr_i;
   logic [DATA_WIDTH-1:0] ex_data_i;
   logic                  ex_tag_i;

   logic                  lsu_valid_i;
   logic                  lsu_ready_o;
   logic [ADDR_WIDTH-1:0] lsu_addr_i;
   logic [DATA_WIDTH-1:0] lsu_data_i;
   logic                  lsu_tag_i;

   logic                  mc_valid_i;
   logic                  mc_ready_o;
   logic [ADDR_WIDTH-1:0] mc_addr_i;
   logic [DATA_WIDTH-1:0] mc_data_i;
   logic                  mc_tag_i;

   logic                  we_a_o;
   logic [ADDR_WIDTH-1:0] waddr_a_o;
   logic [DATA_WIDTH-1:0] wdata_a_o;
   logic                  wtag_a_o;

   logic                  we_b_o;
   logic [ADDR_WIDTH-1:0] waddr_b_o;
   logic [DATA_WIDTH-1:0] wdata_b_o;
   logic                  wtag_b_o;

   logic                  mc_fifo_empty_o;

`ifdef RISCV_WB_SCOREBOARD_EN
   logic                      iss_valid_i;
   logic [ADDR_WIDTH-1:0]     iss_addr_i;
   logic [2**ADDR_WIDTH-1:0]  busy_o;
`endif

   modport slave (
`ifdef RISCV_WB_SCOREBOARD_EN
      input  iss_valid_i, input iss_addr_i, output busy_o,
`endif
      input  ex_valid_i, ex_addr_i, ex_data_i, ex_tag_i,
      input  lsu_valid_i, lsu_addr_i, lsu_data_i, lsu_tag_i,
      output lsu_ready_o,
      input  mc_valid_i, mc_addr_i, mc_data_i, mc_tag_i,
      output mc_ready_o,
      output we_a_o, waddr_a_o, wdata_a_o, wtag_a_o,
      output we_b_o, waddr_b_o, wdata_b_o, wtag_b_o,
      output mc_fifo_empty_o
   );

   modport master (
`ifdef RISCV_WB_SCOREBOARD_EN
      output iss_valid_i, output iss_addr_i, input busy_o,
`endif
      output ex_valid_i, ex_addr_i, ex_data_i, ex_tag_i,
      output lsu_valid_i, lsu_addr_i, lsu_data_i, lsu_tag_i,
      input  lsu_ready_o,
      output mc_valid_i, mc_addr_i, mc_data_i, mc_tag_i,
      input  mc_ready_o,
      input  we_a_o, waddr_a_o, wdata_a_o, wtag_a_o,
      input  we_b_o, waddr_b_o, wdata_b_o, wtag_b_o,
      input  mc_fifo_empty_o
   );

endinterface

// File: rtl/riscv_wb_fifo.sv
// MC result buffer: DEPTH-entry FIFO of wb_req_t, head visible combinationally.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: full_o is exported; caller must not push when full without a pop.
module riscv_wb_fifo
   import riscv_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_i,
   input  wb_req_t push_dat_i,
   input  logic    pop_i,
   output wb_req_t head_o,
   output logic    full_o,
   output logic    empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   wb_req_t       mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q;

   // Storage array: payload only, no reset needed since count gates its use.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: EX -> port A; LSU and buffered MC share port B with anti-starvation.
// Latency: result accepted in cycle N is written (registered outputs) in cycle N+1.
// Backpressure: EX never stalled; lsu_ready_o low only when MC is forced; mc_ready_o = !full || pop.
// Optional busy scoreboard enabled by macro RISCV_WB_SCOREBOARD_EN.
module riscv_wb_arbiter
   import riscv_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_W,
   parameter int DATA_WIDTH = WB_DATA_W,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   riscv_wb_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   wb_req_t       ex_req, lsu_req, mc_req, fifo_head, cand;
   wb_req_t       a_d, a_q, b_d, b_q;
   wb_src_e       src;
   logic          cand_fifo, forced, bypass;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic          ex_wr, collide, we_a_d, we_a_q, we_b_d, we_b_q;
   logic [SW-1:0] starve_q, starve_d;

   assign ex_req  = '{addr: bus.ex_addr_i,  data: bus.ex_data_i,  tag: bus.ex_tag_i};
   assign lsu_req = '{addr: bus.lsu_addr_i, data: bus.lsu_data_i, tag: bus.lsu_tag_i};
   assign mc_req  = '{addr: bus.mc_addr_i,  data: bus.mc_data_i,  tag: bus.mc_tag_i};

   riscv_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mc_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (fifo_push),
      .push_dat_i (mc_req),
      .pop_i      (fifo_pop),
      .head_o     (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // Port-B selection: forced MC, then LSU, then buffered MC, then empty-FIFO MC bypass.
   always_comb begin
      forced    = !fifo_empty && (starve_q == STARVE_LIM);
      src       = SRC_NONE;
      cand      = '0;
      cand_fifo = 1'b0;
      if (forced) begin
         src       = SRC_MC;
         cand      = fifo_head;
         cand_fifo = 1'b1;
      end else if (bus.lsu_valid_i) begin
         src  = SRC_LSU;
         cand = lsu_req;
      end else if (!fifo_empty) begin
         src       = SRC_MC;
         cand      = fifo_head;
         cand_fifo = 1'b1;
      end else if (bus.mc_valid_i) begin
         src  = SRC_MC;
         cand = mc_req;
      end
   end

   assign bypass          = (src == SRC_MC) && !cand_fifo;
   assign fifo_pop        = cand_fifo;
   assign bus.mc_ready_o  = !fifo_full || fifo_pop;
   assign fifo_push       = bus.mc_valid_i && bus.mc_ready_o && !bypass;
   assign bus.lsu_ready_o = bus.lsu_valid_i && !forced;

   // Starvation count: LSU wins while MC waits; any pop clears it.
   always_comb begin
      starve_d = starve_q;
      if (fifo_pop)
         starve_d = '0;
      else if (!fifo_empty && (src == SRC_LSU) && (starve_q != STARVE_LIM))
         starve_d = starve_q + 1'b1;
   end

   // Write enables: EX is the younger result, so it wins a same-register collision.
   always_comb begin
      ex_wr   = bus.ex_valid_i && (bus.ex_addr_i != '0);
      collide = ex_wr && (src != SRC_NONE) && (cand.addr == bus.ex_addr_i);
      we_a_d  = ex_wr;
      we_b_d  = (src != SRC_NONE) && (cand.addr != '0) && !collide;
      a_d     = we_a_d ? ex_req : '0;
      b_d     = we_b_d ? cand   : '0;
   end

   // Registered write ports and starvation counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_a_q   <= 1'b0;
         we_b_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         starve_q <= '0;
      end else begin
         we_a_q   <= we_a_d;
         we_b_q   <= we_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         starve_q <= starve_d;
      end
   end

   assign bus.we_a_o          = we_a_q;
   assign bus.waddr_a_o       = a_q.addr;
   assign bus.wdata_a_o       = a_q.data;
   assign bus.wtag_a_o        = a_q.tag;
   assign bus.we_b_o          = we_b_q;
   assign bus.waddr_b_o       = b_q.addr;
   assign bus.wdata_b_o       = b_q.data;
   assign bus.wtag_b_o        = b_q.tag;
   assign bus.mc_fifo_empty_o = fifo_empty;

`ifdef RISCV_WB_SCOREBOARD_EN
   logic [2**ADDR_WIDTH-1:0] busy_q, busy_d, busy_set, busy_clr;

   // Pending-result scoreboard: issue sets, port-B consumption clears, set wins.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (bus.iss_valid_i && (bus.iss_addr_i != '0)) busy_set[bus.iss_addr_i] = 1'b1;
      if (src != SRC_NONE) busy_clr[cand.addr] = 1'b1;
      busy_d = (busy_q & ~busy_clr) | busy_set;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign bus.busy_o = busy_q;
`endif

endmodule
